peripheral_bus_bridge: RTL and testbench

Bus-slave front end that sits directly upstream of peripheral_core. It converts a single-outstanding req/ack register bus into the native register strobes and data that peripheral_core consumes, and returns register read data. It owns the address decode, error signalling, and the multi-cycle FIFO pop sequence. peripheral_core itself is unchanged.

---
 rtl/peripheral_bus_bridge.sv | 191 +++++++++++++++++++
 tb/tb_peripheral_bus_bridge.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/peripheral_bus_bridge.sv
// rtl/peripheral_bus_bridge.sv - req/ack register bus to peripheral_core strobe bridge
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   bus_req/we/addr/wdata         single-outstanding master request
//   bus_ack/err/rdata             registered one-cycle completion and response
//   count_we/count_in             COUNT load strobe and value
//   config_we/en_in/dir_in/ire_in CONFIG load strobe and fields
//   fifo_we/fifo_data_in          FIFO push strobe and data
//   fifo_re                       FIFO pop strobe
//   count_out, en/dir/ire/lt_1k_out, fifo_data_out, fifo_word_count,
//   fifo_empty, fifo_full         current peripheral_core state
module peripheral_bus_bridge #(
    parameter int ADDR_WIDTH       = 8,
    parameter int FIFO_COUNT_WIDTH = 9
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        bus_req,
    input  logic                        bus_we,
    input  logic [ADDR_WIDTH-1:0]       bus_addr,
    input  logic [31:0]                 bus_wdata,
    output logic                        bus_ack,
    output logic                        bus_err,
    output logic [31:0]                 bus_rdata,
    output logic                        count_we,
    output logic [31:0]                 count_in,
    output logic                        config_we,
    output logic                        en_in,
    output logic                        dir_in,
    output logic                        ire_in,
    output logic                        fifo_we,
    output logic                        fifo_re,
    output logic [7:0]                  fifo_data_in,
    input  logic [31:0]                 count_out,
    input  logic                        en_out,
    input  logic                        dir_out,
    input  logic                        ire_out,
    input  logic                        lt_1k_out,
    input  logic [7:0]                  fifo_data_out,
    input  logic [FIFO_COUNT_WIDTH-1:0] fifo_word_count,
    input  logic                        fifo_empty,
    input  logic                        fifo_full
);

    typedef enum logic [1:0] {IDLE, POP, CAPTURE, ACK} state_t;

    localparam logic [1:0] SEL_COUNT  = 2'd0;
    localparam logic [1:0] SEL_CONFIG = 2'd1;
    localparam logic [1:0] SEL_STATUS = 2'd2;
    localparam logic [1:0] SEL_FIFO   = 2'd3;

    state_t state, state_nxt;

    logic [1:0]  reg_sel;
    logic        addr_bad;
    logic        access_err;
    logic        fifo_pop;
    logic [31:0] read_word;

    logic        bus_ack_nxt, bus_err_nxt;
    logic [31:0] bus_rdata_nxt;
    logic        count_we_nxt, config_we_nxt, fifo_we_nxt, fifo_re_nxt;
    logic [31:0] count_in_nxt;
    logic [2:0]  config_nxt;
    logic [7:0]  fifo_data_in_nxt;

    // Address decode and error classification, evaluated against the
    // flags present at the acceptance edge.
    always_comb begin
        reg_sel    = bus_addr[3:2];
        addr_bad   = (bus_addr[1:0] != 2'b00) || (|bus_addr[ADDR_WIDTH-1:4]);
        access_err = addr_bad
                  || ( bus_we && reg_sel == SEL_STATUS)
                  || ( bus_we && reg_sel == SEL_FIFO && fifo_full)
                  || (!bus_we && reg_sel == SEL_FIFO && fifo_empty);
        fifo_pop   = !access_err && !bus_we && reg_sel == SEL_FIFO;

        read_word = '0;
        case (reg_sel)
            SEL_COUNT:  read_word = count_out;
            SEL_CONFIG: read_word[2:0] = {ire_out, dir_out, en_out};
            SEL_STATUS: begin
                read_word[2:0] = {fifo_full, fifo_empty, lt_1k_out};
                read_word[8 +: FIFO_COUNT_WIDTH] = fifo_word_count;
            end
            default:    read_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus_req) state_nxt = fifo_pop ? POP : ACK;
            POP:     state_nxt = CAPTURE;
            CAPTURE: state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; everything defaults to 0 so
    // strobes and ack are naturally single-cycle.
    always_comb begin
        bus_ack_nxt      = 1'b0;
        bus_err_nxt      = 1'b0;
        bus_rdata_nxt    = '0;
        count_we_nxt     = 1'b0;
        config_we_nxt    = 1'b0;
        fifo_we_nxt      = 1'b0;
        fifo_re_nxt      = 1'b0;
        count_in_nxt     = '0;
        config_nxt       = '0;
        fifo_data_in_nxt = '0;
        case (state)
            IDLE: begin
                if (bus_req) begin
                    if (fifo_pop) begin
                        fifo_re_nxt = 1'b1;
                    end else begin
                        bus_ack_nxt = 1'b1;
                        bus_err_nxt = access_err;
                        if (!access_err) begin
                            if (bus_we) begin
                                case (reg_sel)
                                    SEL_COUNT: begin
                                        count_we_nxt = 1'b1;
                                        count_in_nxt = bus_wdata;
                                    end
                                    SEL_CONFIG: begin
                                        config_we_nxt = 1'b1;
                                        config_nxt    = bus_wdata[2:0];
                                    end
                                    SEL_FIFO: begin
                                        fifo_we_nxt      = 1'b1;
                                        fifo_data_in_nxt = bus_wdata[7:0];
                                    end
                                    default: ;
                                endcase
                            end else begin
                                bus_rdata_nxt = read_word;
                            end
                        end
                    end
                end
            end
            CAPTURE: begin
                // Pop data became valid the cycle after fifo_re.
                bus_ack_nxt   = 1'b1;
                bus_rdata_nxt = {24'b0, fifo_data_out};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_ack      <= 1'b0;
            bus_err      <= 1'b0;
            bus_rdata    <= '0;
            count_we     <= 1'b0;
            count_in     <= '0;
            config_we    <= 1'b0;
            en_in        <= 1'b0;
            dir_in       <= 1'b0;
            ire_in       <= 1'b0;
            fifo_we      <= 1'b0;
            fifo_re      <= 1'b0;
            fifo_data_in <= '0;
        end else begin
            bus_ack      <= bus_ack_nxt;
            bus_err      <= bus_err_nxt;
            bus_rdata    <= bus_rdata_nxt;
            count_we     <= count_we_nxt;
            count_in     <= count_in_nxt;
            config_we    <= config_we_nxt;
            en_in        <= config_nxt[0];
            dir_in       <= config_nxt[1];
            ire_in       <= config_nxt[2];
            fifo_we      <= fifo_we_nxt;
            fifo_re      <= fifo_re_nxt;
            fifo_data_in <= fifo_data_in_nxt;
        end
    end

endmodule

// File: tb/tb_peripheral_bus_bridge.sv
// tb/tb_peripheral_bus_bridge.sv - directed self-checking bench for peripheral_bus_bridge
module tb_peripheral_bus_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        bus_req, bus_we;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack, bus_err;
    logic [31:0] bus_rdata;
    logic        count_we, config_we, en_in, dir_in, ire_in;
    logic [31:0] count_in;
    logic        fifo_we, fifo_re;
    logic [7:0]  fifo_data_in;
    logic [31:0] count_out;
    logic        en_out, dir_out, ire_out, lt_1k_out;
    logic [7:0]  fifo_data_out;
    logic [8:0]  fifo_word_count;
    logic        fifo_empty, fifo_full;
    logic [7:0]  pop_value;

    int n_pass  = 0;
    int n_total = 0;

    int          lat, n_ack, n_cwe, n_cfg, n_fwe, n_fre;
    logic        a_err;
    logic [31:0] a_rdata, cap_count;
    logic [2:0]  cap_cfg;
    logic [7:0]  cap_fifo;

    peripheral_bus_bridge #(.ADDR_WIDTH(8), .FIFO_COUNT_WIDTH(9)) dut (
        .clk(clk), .reset_n(reset_n),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata),
        .count_we(count_we), .count_in(count_in),
        .config_we(config_we), .en_in(en_in), .dir_in(dir_in), .ire_in(ire_in),
        .fifo_we(fifo_we), .fifo_re(fifo_re), .fifo_data_in(fifo_data_in),
        .count_out(count_out), .en_out(en_out), .dir_out(dir_out), .ire_out(ire_out),
        .lt_1k_out(lt_1k_out), .fifo_data_out(fifo_data_out),
        .fifo_word_count(fifo_word_count), .fifo_empty(fifo_empty), .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    // Minimal FIFO read-port model: data appears the cycle after a pop.
    always @(posedge clk) if (fifo_re) fifo_data_out <= pop_value;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] out_flags();
        return {20'b0, bus_ack, bus_err, count_we, config_we, fifo_we, fifo_re,
                en_in, dir_in, ire_in, |bus_rdata, |count_in, |fifo_data_in};
    endfunction

    task automatic sample_strobes();
        if (bus_ack)   n_ack++;
        if (count_we)  begin n_cwe++; cap_count = count_in; end
        if (config_we) begin n_cfg++; cap_cfg = {ire_in, dir_in, en_in}; end
        if (fifo_we)   begin n_fwe++; cap_fifo = fifo_data_in; end
        if (fifo_re)   n_fre++;
    endtask

    // One master transaction; latency counted in cycles from the acceptance edge.
    task automatic access(input logic we, input logic [7:0] addr, input logic [31:0] wdata);
        lat = 0; n_ack = 0; n_cwe = 0; n_cfg = 0; n_fwe = 0; n_fre = 0;
        a_err = 1'b0; a_rdata = '0; cap_count = '0; cap_cfg = '0; cap_fifo = '0;
        @(negedge clk);
        bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
        while (n_ack == 0 && lat < 20) begin
            @(negedge clk);
            lat++;
            sample_strobes();
            if (bus_ack) begin a_err = bus_err; a_rdata = bus_rdata; end
        end
        bus_req = 1'b0;
        if (n_ack == 0) lat = 99;
        @(negedge clk);
        sample_strobes();
    endtask

    initial begin
        reset_n = 1'b0;
        bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        count_out = '0; en_out = 1'b0; dir_out = 1'b0; ire_out = 1'b0; lt_1k_out = 1'b0;
        fifo_word_count = '0; fifo_empty = 1'b0; fifo_full = 1'b0;
        pop_value = 8'hA5;
        fifo_data_out = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", out_flags(), 32'h0);
        reset_n = 1'b1;

        access(1'b1, 8'h00, 32'h0000_1234);
        check("cnt_wr_lat", lat, 1);
        check("cnt_wr_err", a_err, 0);
        check("cnt_wr_we", n_cwe, 1);
        check("cnt_wr_data", cap_count, 32'h0000_1234);
        check("cnt_wr_other", n_cfg + n_fwe + n_fre, 0);
        check("cnt_wr_ack1", n_ack, 1);

        access(1'b1, 8'h00, 32'hCAFE_F00D);
        check("cnt_wr_full32", cap_count, 32'hCAFE_F00D);

        count_out = 32'hDEAD_BEEF;
        access(1'b0, 8'h00, 32'h0);
        check("cnt_rd_data", a_rdata, 32'hDEAD_BEEF);
        check("cnt_rd_strobes", n_cwe + n_cfg + n_fwe + n_fre, 0);

        access(1'b1, 8'h04, 32'hFFFF_FFFF);
        check("cfg_wr_we", n_cfg, 1);
        check("cfg_wr_fields", cap_cfg, 3'b111);
        access(1'b1, 8'h04, 32'hFFFF_FFF2);
        check("cfg_wr_dir_only", cap_cfg, 3'b010);

        en_out = 1'b1; dir_out = 1'b1; ire_out = 1'b1;
        access(1'b0, 8'h04, 32'h0);
        check("cfg_rd_data", a_rdata, 32'h0000_0007);

        access(1'b1, 8'h0C, 32'h1234_56A5);
        check("fifo_wr_we", n_fwe, 1);
        check("fifo_wr_data", cap_fifo, 8'hA5);
        check("fifo_wr_err", a_err, 0);

        access(1'b0, 8'h0C, 32'h0);
        check("fifo_rd_lat", lat, 3);
        check("fifo_rd_re", n_fre, 1);
        check("fifo_rd_data", a_rdata, 32'h0000_00A5);
        check("fifo_rd_err", a_err, 0);

        fifo_empty = 1'b1;
        access(1'b0, 8'h0C, 32'h0);
        check("fifo_empty_err", a_err, 1);
        check("fifo_empty_re", n_fre, 0);
        check("fifo_empty_rdata", a_rdata, 32'h0);
        check("fifo_empty_lat", lat, 1);
        fifo_empty = 1'b0;

        fifo_full = 1'b1;
        access(1'b1, 8'h0C, 32'h0000_0011);
        check("fifo_full_err", a_err, 1);
        check("fifo_full_we", n_fwe, 0);
        fifo_full = 1'b0;

        access(1'b1, 8'h02, 32'h1);
        check("misalign_err", a_err, 1);
        check("misalign_strobes", n_cwe + n_cfg + n_fwe + n_fre, 0);
        access(1'b0, 8'h10, 32'h0);
        check("oob_err", a_err, 1);
        check("oob_rdata", a_rdata, 32'h0);
        access(1'b1, 8'h08, 32'hFFFF_FFFF);
        check("status_wr_err", a_err, 1);
        check("status_wr_strobes", n_cwe + n_cfg + n_fwe + n_fre, 0);

        lt_1k_out = 1'b1; fifo_empty = 1'b0; fifo_full = 1'b1; fifo_word_count = 9'd256;
        access(1'b0, 8'h08, 32'h0);
        check("status_rd_data", a_rdata, 32'h0001_0005);
        check("status_rd_err", a_err, 0);
        fifo_full = 1'b0;

        // Reset asserted while the pop is in flight.
        @(negedge clk);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 8'h0C;
        @(negedge clk);
        check("pop_issued", fifo_re, 1);
        #2 reset_n = 1'b0;
        #1 check("reset_mid_outputs", out_flags(), 32'h0);
        n_ack = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus_ack) n_ack++;
        end
        bus_req = 1'b0;
        check("reset_mid_no_ack", n_ack, 0);
        reset_n = 1'b1;

        count_out = 32'h0BAD_F00D;
        access(1'b0, 8'h00, 32'h0);
        check("post_reset_lat", lat, 1);
        check("post_reset_data", a_rdata, 32'h0BAD_F00D);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
